// File: rtl/mem_stage.sv
// MEM stage: turns an EX/MEM entry into a data-memory request/grant/response transaction and a registered MEM/WB entry.
// Latency 1 for non-memory ops; a memory op holds upstream through stall until grant (store) or rvalid (load), or until timeout.
module mem_stage #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] sd,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_exc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    lat_size;
  logic          lat_uns;
  logic [1:0]    lat_off;
  logic [4:0]    lat_rd;
  logic          lat_rw;

  logic        mem_op, illegal, misaligned, accept;
  logic        tmo, store_done, load_done, abort;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, shifted, load_data;

  assign mem_op     = mem_read | mem_write;
  assign illegal    = (mem_read & mem_write) | (mem_size == 2'd3);
  assign misaligned = ((mem_size == 2'd1) & alu_result[0]) |
                      ((mem_size == 2'd2) & (alu_result[1:0] != 2'd0));
  assign accept     = (state == IDLE) & in_valid & mem_op & ~illegal & ~misaligned;

  assign tmo        = (cnt == CW'(TIMEOUT - 1));
  assign store_done = (state == REQ) & dmem_we & dmem_gnt;
  assign load_done  = (state == WAIT) & dmem_rvalid;
  // Completion wins over the timeout when both land on the last cycle.
  assign abort      = (state != IDLE) & tmo & ~store_done & ~load_done;

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = accept;
      REQ:     stall = ~store_done & ~abort;
      WAIT:    stall = ~load_done & ~abort;
      default: stall = 1'b0;
    endcase
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = sd;
    case (mem_size)
      2'd0: begin
        be_calc    = 4'b0001 << alu_result[1:0];
        wdata_calc = {4{sd[7:0]}};
      end
      2'd1: begin
        be_calc    = 4'b0011 << alu_result[1:0];
        wdata_calc = {2{sd[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = dmem_rdata >> {lat_off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (lat_size)
      2'd0:    load_data = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_size     <= 2'd0;
      lat_uns      <= 1'b0;
      lat_off      <= 2'd0;
      lat_rd       <= 5'd0;
      lat_rw       <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_be      <= 4'd0;
      dmem_wdata   <= 32'd0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      mem_exc      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_exc  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !mem_op) begin
            wb_valid     <= 1'b1;
            wb_data      <= alu_result;
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
          end else if (in_valid && (illegal || misaligned)) begin
            mem_exc <= 1'b1;
          end else if (accept) begin
            lat_size   <= mem_size;
            lat_uns    <= mem_unsigned;
            lat_off    <= alu_result[1:0];
            lat_rd     <= rd;
            lat_rw     <= reg_write;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_be    <= be_calc;
            dmem_wdata <= wdata_calc;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (abort) begin
            dmem_req <= 1'b0;
            mem_exc  <= 1'b1;
            state    <= IDLE;
          end else if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              wb_valid     <= 1'b1;
              wb_data      <= 32'd0;
              wb_rd        <= lat_rd;
              wb_reg_write <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (load_done) begin
            wb_valid     <= 1'b1;
            wb_data      <= load_data;
            wb_rd        <= lat_rd;
            wb_reg_write <= lat_rw;
            state        <= IDLE;
          end else if (abort) begin
            mem_exc <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
